// File: rtl/shift_ctrl_pkg.sv
// Shared types for the serial capture sequencer: FSM state encoding and the
// delivered-word counter width.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    localparam int WORDCNT_W = 8;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Data-driven sequencer: counts serial bits into words, pulses the sync_reg load,
// then holds the word valid until the decode stage takes it (valid/ready).
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 4,
    localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                 fastClk,
    input  logic                 reset,
    input  logic                 control,
    input  logic                 bitValid,
    input  logic                 downReady,
    output logic                 shiftEn,
    output logic                 loadEn,
    output logic                 wordValid,
    output logic [CNT_W-1:0]     bitCount,
    output logic                 overrun,
    output logic [WORDCNT_W-1:0] wordCount,
    output seq_state_e           dbgState
);

    // Handshake: wordValid rises the cycle after loadEn and stays high, independent
    // of downReady, until an edge samples wordValid & downReady; that edge is the
    // transfer. The word is never withdrawn except by reset.

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    seq_state_e           state_q, state_d;
    logic [CNT_W-1:0]     bitCount_q, bitCount_d;
    logic [WORDCNT_W-1:0] wordCount_q, wordCount_d;
    logic                 overrun_q, overrun_d;

    always_ff @(posedge fastClk) begin
        if (reset) begin
            state_q     <= IDLE;
            bitCount_q  <= '0;
            wordCount_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCount_q  <= bitCount_d;
            wordCount_q <= wordCount_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitCount_d  = bitCount_q;
        wordCount_d = wordCount_q;
        overrun_d   = overrun_q;
        shiftEn     = 1'b0;
        loadEn      = 1'b0;
        wordValid   = 1'b0;
        case (state_q)
            IDLE: begin
                overrun_d = 1'b0;
                if (control) begin
                    state_d    = SHIFT;
                    bitCount_d = '0;
                end
            end
            SHIFT: begin
                shiftEn = bitValid & control;
                // Dropping control abandons the partial word even on its last bit.
                if (!control) begin
                    state_d    = IDLE;
                    bitCount_d = '0;
                end else if (bitValid) begin
                    if (bitCount_q == LAST_BIT) begin
                        state_d    = LOAD;
                        bitCount_d = '0;
                    end else begin
                        bitCount_d = bitCount_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                loadEn  = 1'b1;
                state_d = HOLD;
                if (bitValid) overrun_d = 1'b1;
            end
            HOLD: begin
                wordValid = 1'b1;
                if (bitValid) overrun_d = 1'b1;
                // control only chooses where to go after delivery; it never cancels it.
                if (downReady) begin
                    wordCount_d = wordCount_q + 1'b1;
                    state_d     = control ? SHIFT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bitCount  = bitCount_q;
    assign wordCount = wordCount_q;
    assign overrun   = overrun_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a cycle-level reference model and
// hand-computed spot checks.
module tb_shift_seq_ctrl;
    import shift_ctrl_pkg::*;

    localparam int DW    = 4;
    localparam int CW    = $clog2(DW);

    logic                 fastClk;
    logic                 reset;
    logic                 control;
    logic                 bitValid;
    logic                 downReady;
    logic                 shiftEn;
    logic                 loadEn;
    logic                 wordValid;
    logic [CW-1:0]        bitCount;
    logic                 overrun;
    logic [WORDCNT_W-1:0] wordCount;
    seq_state_e           dbgState;

    int tests_run = 0;
    int tests_failed = 0;

    shift_seq_ctrl #(.DATA_WIDTH(DW)) dut (
        .fastClk  (fastClk),
        .reset    (reset),
        .control  (control),
        .bitValid (bitValid),
        .downReady(downReady),
        .shiftEn  (shiftEn),
        .loadEn   (loadEn),
        .wordValid(wordValid),
        .bitCount (bitCount),
        .overrun  (overrun),
        .wordCount(wordCount),
        .dbgState (dbgState)
    );

    // clock
    initial fastClk = 1'b0;
    always #5 fastClk = ~fastClk;

    // reference model: capture mode, bits gathered, load pulse due, word pending
    bit m_valid = 1'b0;
    bit m_capturing, m_load_due, m_pending, m_ovr;
    int m_bits, m_words;

    always @(negedge fastClk) begin
        if (m_valid) begin
            logic e_shift;
            e_shift = m_capturing && control && bitValid;
            tests_run++;
            if (shiftEn !== e_shift || loadEn !== m_load_due || wordValid !== m_pending ||
                int'(bitCount) != m_bits || overrun !== m_ovr || int'(wordCount) != m_words ||
                $isunknown({shiftEn, loadEn, wordValid, bitCount, overrun, wordCount})) begin
                tests_failed++;
                $display("FAIL model t=%0t: got sh=%b ld=%b wv=%b bc=%0d ov=%b wc=%0d, expected sh=%b ld=%b wv=%b bc=%0d ov=%b wc=%0d",
                         $time, shiftEn, loadEn, wordValid, bitCount, overrun, wordCount,
                         e_shift, m_load_due, m_pending, m_bits, m_ovr, m_words);
            end
        end
        if (reset) begin
            m_valid = 1'b1;
            m_capturing = 0; m_load_due = 0; m_pending = 0; m_ovr = 0;
            m_bits = 0; m_words = 0;
        end else if (m_valid) begin
            if (m_load_due) begin
                m_load_due = 0;
                m_pending = 1;
                if (bitValid) m_ovr = 1;
            end else if (m_pending) begin
                if (bitValid) m_ovr = 1;
                if (downReady) begin
                    m_words = (m_words + 1) % 256;
                    m_pending = 0;
                    m_capturing = control;
                end
            end else if (m_capturing) begin
                if (!control) begin
                    m_capturing = 0;
                    m_bits = 0;
                end else if (bitValid) begin
                    if (m_bits == DW - 1) begin
                        m_bits = 0;
                        m_capturing = 0;
                        m_load_due = 1;
                    end else begin
                        m_bits++;
                    end
                end
            end else begin
                m_ovr = 0;
                if (control) begin
                    m_capturing = 1;
                    m_bits = 0;
                end
            end
        end
    end

    // driver tasks
    task automatic step(input logic c, input logic bv, input logic dr);
        control = c; bitValid = bv; downReady = dr;
        @(posedge fastClk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic word_bits();
        for (int i = 0; i < DW; i++) step(1, 1, 0);
    endtask

    initial begin
        reset = 1; control = 0; bitValid = 0; downReady = 0;

        // 1: reset, then one word
        step(0, 0, 0);
        step(0, 0, 0);
        chk("reset_state", int'(dbgState), int'(IDLE));
        chk("reset_outs", int'({loadEn, wordValid, overrun, bitCount}), 0);
        chk("reset_wc", int'(wordCount), 0);
        reset = 0;
        step(1, 1, 0);
        chk("idle_to_shift", int'(dbgState), int'(SHIFT));
        chk("idle_bit_ignored", int'(bitCount), 0);
        control = 1; bitValid = 1; #1;
        chk("shiftEn_comb", int'(shiftEn), 1);
        for (int i = 0; i < DW; i++) begin
            step(1, 1, 0);
            chk("bitcount_seq", int'(bitCount), (i + 1) % DW);
        end
        chk("loadEn_pulse", int'(loadEn), 1);
        chk("no_wv_in_load", int'(wordValid), 0);
        step(1, 0, 0);
        chk("wv_after_load", int'(wordValid), 1);
        chk("load_one_cycle", int'(loadEn), 0);

        // 2: held word, then handshake
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            chk("wv_held", int'(wordValid), 1);
        end
        chk("wc_before_hs", int'(wordCount), 0);
        step(1, 0, 1);
        chk("wv_dropped", int'(wordValid), 0);
        chk("wc_after_hs", int'(wordCount), 1);
        chk("back_to_shift", int'(dbgState), int'(SHIFT));

        // 3: overrun on bits during LOAD/HOLD, sticky until IDLE
        word_bits();
        step(1, 1, 0);
        chk("overrun_set", int'(overrun), 1);
        step(1, 1, 1);
        chk("overrun_hs_wc", int'(wordCount), 2);
        word_bits();
        step(1, 0, 0);
        step(1, 0, 1);
        chk("overrun_sticky", int'(overrun), 1);
        chk("wc_3", int'(wordCount), 3);
        step(0, 0, 0);
        chk("abort_idle", int'(dbgState), int'(IDLE));
        step(0, 0, 0);
        chk("overrun_cleared", int'(overrun), 0);

        // 4: abort on the last bit
        step(1, 0, 0);
        for (int i = 0; i < DW - 1; i++) step(1, 1, 0);
        chk("partial_bits", int'(bitCount), DW - 1);
        step(0, 1, 0);
        chk("abort_wins", int'(dbgState), int'(IDLE));
        chk("abort_bc", int'(bitCount), 0);
        step(0, 0, 0);
        chk("abort_no_load", int'(loadEn), 0);
        chk("abort_wc", int'(wordCount), 3);

        // 5: control low during HOLD still delivers
        step(1, 0, 0);
        word_bits();
        step(0, 0, 0);
        step(0, 0, 0);
        chk("hold_no_cancel", int'(wordValid), 1);
        step(0, 0, 1);
        chk("hold_deliver_wc", int'(wordCount), 4);
        chk("hold_to_idle", int'(dbgState), int'(IDLE));

        // 6: wrap after 256 words, then reset mid-word
        reset = 1;
        step(0, 0, 0);
        reset = 0;
        chk("wrap_start", int'(wordCount), 0);
        step(1, 0, 0);
        for (int w = 0; w < 256; w++) begin
            word_bits();
            step(1, 0, 0);
            step(1, 0, 1);
            if (w == 254) chk("wc_255", int'(wordCount), 255);
        end
        chk("wc_wrap", int'(wordCount), 0);
        step(1, 1, 0);
        step(1, 1, 0);
        chk("mid_bc2", int'(bitCount), 2);
        reset = 1;
        step(1, 1, 0);
        chk("midreset_state", int'(dbgState), int'(IDLE));
        chk("midreset_outs", int'({loadEn, wordValid, overrun, bitCount, wordCount}), 0);
        reset = 0;
        step(0, 0, 0);
        step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
